// File: rtl/debug_coprocessor_pkg.sv
// Shared types and constants for the debug coprocessor: opcodes, FSM states,
// io_control bit positions and response codes.
package debug_coprocessor_pkg;

  localparam int unsigned IO_ADDR_W  = 15;
  localparam int unsigned IO_CTL_W   = 5;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned CSR_ADDR_W = 12;

  localparam int unsigned CTL_WE   = 0;
  localparam int unsigned CTL_RD   = 1;
  localparam int unsigned CTL_CSR  = 3;
  localparam int unsigned CTL_HALT = 4;

  localparam logic [7:0] ACK = 8'hAA;
  localparam logic [7:0] ERR = 8'hEE;

  typedef enum logic [7:0] {
    OP_HALT   = 8'h01,
    OP_RESUME = 8'h02,
    OP_STEP   = 8'h03,
    OP_RDREG  = 8'h10,
    OP_WRREG  = 8'h11,
    OP_RDCSR  = 8'h20
  } dbg_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARGS,
    ST_ACCESS,
    ST_STEP,
    ST_RESP
  } dbg_state_t;

  // Quiescent io_control value: only the halt hold bit may be set
  function automatic logic [IO_CTL_W-1:0] ctl_idle(input logic halted);
    ctl_idle           = '0;
    ctl_idle[CTL_HALT] = halted;
  endfunction

endpackage

// File: rtl/debug_tx_serializer.sv
// Response serializer: loads a full N-bit word or a single byte and emits it
// LSB first over the tx valid/ready handshake, pulsing done after the last byte.
module debug_tx_serializer #(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         single,
  input  logic [N-1:0] word,
  input  logic         tx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  output logic         done
);

  localparam int unsigned NB    = N / 8;
  localparam int unsigned CNT_W = $clog2(NB + 1);

  logic [N-1:0]     shreg;
  logic [CNT_W-1:0] remain;

  // Byte counter only moves on an accepted handshake, so tx_data holds while stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg    <= '0;
      remain   <= '0;
      tx_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        shreg    <= single ? N'(word[7:0]) : word;
        remain   <= single ? CNT_W'(1) : CNT_W'(NB);
        tx_valid <= 1'b1;
      end else if (tx_valid && tx_ready) begin
        if (remain == CNT_W'(1)) begin
          tx_valid <= 1'b0;
          done     <= 1'b1;
          remain   <= '0;
        end else begin
          shreg  <= shreg >> 8;
          remain <= remain - CNT_W'(1);
        end
      end
    end
  end

  assign tx_data = shreg[7:0];

endmodule

// File: rtl/debug_coprocessor.sv
// Byte-stream debug controller for the datapath coprocessor IO port.
// Define DEBUG_CSR_ACCESS_EN to enable the RDCSR (0x20) command.
module debug_coprocessor
  import debug_coprocessor_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic [IO_ADDR_W-1:0] io_addr,
  output logic [IO_CTL_W-1:0]  io_control,
  output logic [N-1:0]        io_data_out,
  input  logic [N-1:0]        io_data_in,
  output logic                halted
);

  localparam int unsigned NB    = N / 8;
  localparam int unsigned CNT_W = $clog2(NB + 1);
`ifdef DEBUG_CSR_ACCESS_EN
  localparam int unsigned ADDR_W = CSR_ADDR_W;
`else
  localparam int unsigned ADDR_W = REG_ADDR_W;
`endif

  dbg_state_t          state, state_d;
  dbg_op_t             op, op_d;
  logic [CNT_W-1:0]    cnt, cnt_d, last_idx;
  logic [ADDR_W-1:0]   addr, addr_d;
  logic [N-1:0]        wdata, wdata_d;
  logic                halted_d, rx_ready_d;
  logic [IO_ADDR_W-1:0] io_addr_d;
  logic [IO_CTL_W-1:0]  io_control_d, access_ctl;
  logic [N-1:0]        io_data_out_d;
  logic                go_access, go_step;
  logic                ser_load, ser_single, ser_done;
  logic [N-1:0]        ser_word;

  // Index of the final argument byte for the pending command
  always_comb begin
    last_idx = '0;
    if (op == OP_WRREG) last_idx = CNT_W'(NB);
`ifdef DEBUG_CSR_ACCESS_EN
    if (op == OP_RDCSR) last_idx = CNT_W'(1);
`endif
  end

  always_comb begin
    state_d       = state;
    op_d          = op;
    cnt_d         = cnt;
    addr_d        = addr;
    wdata_d       = wdata;
    halted_d      = halted;
    io_addr_d     = '0;
    io_data_out_d = io_data_out;
    access_ctl    = '0;
    go_access     = 1'b0;
    go_step       = 1'b0;
    ser_load      = 1'b0;
    ser_single    = 1'b1;
    ser_word      = N'(ACK);

    unique case (state)
      ST_IDLE: begin
        if (rx_valid && rx_ready) begin
          cnt_d    = '0;
          ser_load = 1'b1;
          ser_word = N'(ERR);
          state_d  = ST_RESP;
          case (rx_data)
            OP_HALT: begin
              halted_d = 1'b1;
              ser_word = N'(ACK);
            end
            OP_RESUME: begin
              halted_d = 1'b0;
              ser_word = N'(ACK);
            end
            OP_STEP: begin
              if (halted) begin
                ser_load = 1'b0;
                go_step  = 1'b1;
                state_d  = ST_STEP;
              end
            end
            OP_RDREG, OP_WRREG: begin
              ser_load = 1'b0;
              op_d     = dbg_op_t'(rx_data);
              state_d  = ST_ARGS;
            end
`ifdef DEBUG_CSR_ACCESS_EN
            OP_RDCSR: begin
              ser_load = 1'b0;
              op_d     = OP_RDCSR;
              state_d  = ST_ARGS;
            end
`endif
            default: ;
          endcase
        end
      end

      // Arguments are always consumed so the byte stream stays framed, even when rejected
      ST_ARGS: begin
        if (rx_valid && rx_ready) begin
          cnt_d = cnt + CNT_W'(1);
          if (op == OP_WRREG && cnt != '0) wdata_d = {rx_data, wdata[N-1:8]};
`ifdef DEBUG_CSR_ACCESS_EN
          else if (op == OP_RDCSR && cnt == CNT_W'(1)) addr_d[CSR_ADDR_W-1:8] = rx_data[CSR_ADDR_W-9:0];
`endif
          else if (cnt == '0) addr_d = ADDR_W'(rx_data);
          if (cnt == last_idx) begin
            if (halted) begin
              go_access = 1'b1;
              state_d   = ST_ACCESS;
            end else begin
              ser_load = 1'b1;
              ser_word = N'(ERR);
              state_d  = ST_RESP;
            end
          end
        end
      end

      // io_data_in is sampled by the serializer at the end of the access cycle
      ST_ACCESS: begin
        ser_load = 1'b1;
        state_d  = ST_RESP;
        if (op != OP_WRREG) begin
          ser_word   = io_data_in;
          ser_single = 1'b0;
        end
      end

      ST_STEP: begin
        ser_load = 1'b1;
        state_d  = ST_RESP;
      end

      ST_RESP: begin
        if (ser_done) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (go_access) begin
      if (op == OP_WRREG) begin
        access_ctl[CTL_WE] = 1'b1;
        io_data_out_d      = wdata_d;
      end else begin
        access_ctl[CTL_RD] = 1'b1;
      end
`ifdef DEBUG_CSR_ACCESS_EN
      if (op == OP_RDCSR) begin
        access_ctl[CTL_CSR] = 1'b1;
        io_addr_d           = IO_ADDR_W'(addr_d);
      end else
`endif
      io_addr_d = IO_ADDR_W'(addr_d[REG_ADDR_W-1:0]);
    end

    io_control_d = go_step ? '0 : (ctl_idle(halted_d) | access_ctl);
    rx_ready_d   = (state_d == ST_IDLE) || (state_d == ST_ARGS);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      op          <= OP_HALT;
      cnt         <= '0;
      addr        <= '0;
      wdata       <= '0;
      halted      <= 1'b0;
      rx_ready    <= 1'b1;
      io_addr     <= '0;
      io_control  <= '0;
      io_data_out <= '0;
    end else begin
      state       <= state_d;
      op          <= op_d;
      cnt         <= cnt_d;
      addr        <= addr_d;
      wdata       <= wdata_d;
      halted      <= halted_d;
      rx_ready    <= rx_ready_d;
      io_addr     <= io_addr_d;
      io_control  <= io_control_d;
      io_data_out <= io_data_out_d;
    end
  end

  debug_tx_serializer #(.N(N)) u_tx (
    .clk      (clk),
    .reset    (reset),
    .load     (ser_load),
    .single   (ser_single),
    .word     (ser_word),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .done     (ser_done)
  );

endmodule

// File: tb/tb_debug_coprocessor.sv
// Directed bench for debug_coprocessor: hand-written corner sequences followed
// by a table of command/response vectors.
module tb_debug_coprocessor;

  localparam logic [63:0] RD_WORD = 64'hDEADBEEF_CAFEF00D;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [14:0] io_addr;
  logic [4:0]  io_control;
  logic [63:0] io_data_out;
  logic [63:0] io_data_in;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  debug_coprocessor #(.N(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .io_addr     (io_addr),
    .io_control  (io_control),
    .io_data_out (io_data_out),
    .io_data_in  (io_data_in),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  ncmd;
    logic [79:0] cmd;   // byte i at [8*i +: 8]
    logic [3:0]  nresp;
    logic [63:0] resp;  // byte i at [8*i +: 8]
    logic        halted;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!rx_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout: rx_ready=%b expected 1 for byte %h", rx_ready, b);
    end else begin
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic recv_byte(input string name, input logic [7:0] exp);
    int n = 0;
    while (!tx_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!tx_valid || tx_data !== exp) begin
      failures++;
      $display("FAIL %s: tx_data=%h tx_valid=%b expected %h", name, tx_data, tx_valid, exp);
    end
    if (tx_valid) begin
      tx_ready = 1'b1;
      @(posedge clk); #1;
      tx_ready = 1'b0;
    end
  endtask

  task automatic recv_word(input string name, input logic [63:0] w);
    logic [63:0] t;
    t = w;
    for (int i = 0; i < 8; i++) recv_byte(name, t[8*i +: 8]);
  endtask

  initial begin
    vec_t v;
    logic [63:0] vresp;
    logic [79:0] vcmd;

    vecs[0] = '{4'd1,  80'h01, 4'd1, 64'hAA, 1'b1};
    vecs[1] = '{4'd10, 80'h8877665544332211_07_11, 4'd1, 64'hAA, 1'b1};
    vecs[2] = '{4'd2,  80'h1F_10, 4'd8, RD_WORD, 1'b1};
    vecs[3] = '{4'd2,  80'hE5_10, 4'd8, RD_WORD, 1'b1};
    vecs[4] = '{4'd1,  80'h03, 4'd1, 64'hAA, 1'b1};
    vecs[5] = '{4'd1,  80'h02, 4'd1, 64'hAA, 1'b0};
    vecs[6] = '{4'd10, 80'h0102030405060708_02_11, 4'd1, 64'hEE, 1'b0};
    vecs[7] = '{4'd1,  80'h03, 4'd1, 64'hEE, 1'b0};
    vecs[8] = '{4'd1,  80'h7F, 4'd1, 64'hEE, 1'b0};

    io_data_in = RD_WORD;
    tx_ready   = 1'b0;
    rx_data    = 8'h01;
    rx_valid   = 1'b1;
    reset      = 1'b0;

    // Reset with rx_valid held
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_ready",   64'(rx_ready),    64'd1);
    chk("rst_tx_valid",   64'(tx_valid),    64'd0);
    chk("rst_tx_data",    64'(tx_data),     64'd0);
    chk("rst_io_addr",    64'(io_addr),     64'd0);
    chk("rst_io_control", 64'(io_control),  64'd0);
    chk("rst_io_data_out", io_data_out,     64'd0);
    chk("rst_halted",     64'(halted),      64'd0);
    reset = 1'b1;

    // HALT
    send_byte(8'h01);
    chk("halt_halted", 64'(halted),     64'd1);
    chk("halt_ctl",    64'(io_control), 64'b10000);
    recv_byte("halt_ack", 8'hAA);

    // WRREG reg 5
    send_byte(8'h11); send_byte(8'h05);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    chk("wr_access_ctl",  64'(io_control), 64'b10001);
    chk("wr_access_addr", 64'(io_addr),    64'd5);
    chk("wr_data_out",    io_data_out,     64'h0807060504030201);
    @(posedge clk); #1;
    chk("wr_ctl_after",   64'(io_control), 64'b10000);
    recv_byte("wr_ack", 8'hAA);

    // RDREG reg 5
    send_byte(8'h10); send_byte(8'h05);
    chk("rd_access_ctl",  64'(io_control), 64'b10010);
    chk("rd_access_addr", 64'(io_addr),    64'd5);
    @(posedge clk); #1;
    chk("rd_ctl_after",   64'(io_control), 64'b10000);
    recv_word("rd_resp", RD_WORD);

    // STEP while halted, with tx back-pressure
    send_byte(8'h03);
    chk("step_ctl_zero", 64'(io_control), 64'd0);
    @(posedge clk); #1;
    chk("step_ctl_back", 64'(io_control), 64'b10000);
    chk("step_halted",   64'(halted),     64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("step_hold_valid", 64'(tx_valid), 64'd1);
      chk("step_hold_data",  64'(tx_data),  64'hAA);
      @(posedge clk); #1;
    end
    recv_byte("step_ack", 8'hAA);

    // CSR read while halted
`ifdef DEBUG_CSR_ACCESS_EN
    send_byte(8'h20); send_byte(8'h00); send_byte(8'h03);
    chk("csr_access_ctl",  64'(io_control), 64'b11010);
    chk("csr_access_addr", 64'(io_addr),    64'h300);
    @(posedge clk); #1;
    chk("csr_ctl_after",   64'(io_control), 64'b10000);
    recv_word("csr_resp", RD_WORD);
`else
    send_byte(8'h20);
    recv_byte("csr_err", 8'hEE);
    chk("csr_ctl_after", 64'(io_control), 64'b10000);
`endif

    // RESUME then illegal commands while running
    send_byte(8'h02);
    recv_byte("resume_ack", 8'hAA);
    chk("resume_halted", 64'(halted), 64'd0);
    send_byte(8'h10);
    chk("run_rd_ctl0", 64'(io_control), 64'd0);
    send_byte(8'h03);
    chk("run_rd_ctl1", 64'(io_control), 64'd0);
    recv_byte("run_rd_err", 8'hEE);
    chk("run_rd_ctl2", 64'(io_control), 64'd0);
    send_byte(8'h03);
    chk("run_step_ctl", 64'(io_control), 64'd0);
    recv_byte("run_step_err", 8'hEE);

    // Reset in the middle of a halted WRREG
    send_byte(8'h01);
    recv_byte("mid_halt_ack", 8'hAA);
    send_byte(8'h11); send_byte(8'h05); send_byte(8'h01); send_byte(8'h02);
    reset = 1'b0;
    #1;
    chk("mid_rst_halted",   64'(halted),     64'd0);
    chk("mid_rst_ctl",      64'(io_control), 64'd0);
    chk("mid_rst_rx_ready", 64'(rx_ready),   64'd1);
    @(posedge clk); #1;
    reset = 1'b1;

    // Table of command/response vectors
    for (int k = 0; k < 9; k++) begin
      v     = vecs[k];
      vcmd  = v.cmd;
      vresp = v.resp;
      for (int i = 0; i < int'(v.ncmd); i++) send_byte(vcmd[8*i +: 8]);
      for (int i = 0; i < int'(v.nresp); i++)
        recv_byte($sformatf("vec%0d_resp%0d", k, i), vresp[8*i +: 8]);
      chk($sformatf("vec%0d_halted", k), 64'(halted), 64'(v.halted));
      chk($sformatf("vec%0d_ctl", k), 64'(io_control), {59'd0, v.halted, 4'd0});
    end

    repeat (4) @(posedge clk);
    #1;
    chk("final_tx_idle", 64'(tx_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
